// File: rtl/pll_lock_sequencer_if.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer_if
//
// Groups the PLL-facing and status signals of pll_lock_sequencer.
//
// Signals:
//   pll_locked   PLL locked output, asynchronous to refclk
//   relock_req   single-cycle request to restart the lock sequence
//   pll_rst      drives the PLL reset input
//   ready        PLL locked and stable; releases downstream logic
//   fault        PLL never locked within the retry budget
//   retry_count  lock timeouts since the last RUN entry or restart
//   loss_count   lock-loss events seen in RUN (0 unless the counter is built)
//
// Modports:
//   master  environment side: drives pll_locked/relock_req, observes status
//   slave   sequencer side: samples pll_locked/relock_req, drives status
// ---------------------------------------------------------------------------
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       ready;
  logic       fault;
  logic [2:0] retry_count;
  logic [7:0] loss_count;

  modport master (
    output pll_locked,
    output relock_req,
    input  pll_rst,
    input  ready,
    input  fault,
    input  retry_count,
    input  loss_count
  );

  modport slave (
    input  pll_locked,
    input  relock_req,
    output pll_rst,
    output ready,
    output fault,
    output retry_count,
    output loss_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Sequences reset and lock acquisition of the video pixel-clock PLL from the
// 50 MHz reference clock. The PLL is held in reset for RESET_CYCLES, then the
// block waits up to LOCK_TIMEOUT cycles for lock, retrying up to RETRY_LIMIT
// times before declaring a fault. Lock must then hold for STABLE_CYCLES
// consecutive cycles before ready is raised.
//
// Ports:
//   refclk   sole clock, all state updates on its rising edge
//   rst      synchronous active-high reset
//   pll_if   slave modport of pll_lock_sequencer_if
//              in : pll_locked, relock_req
//              out: pll_rst, ready, fault, retry_count[2:0], loss_count[7:0]
//
// Optional feature:
//   PLL_SEQ_LOSS_COUNT_EN  when defined, loss_count counts RUN lock-loss
//                          events (saturating at 255, cleared only by rst).
//                          When undefined, loss_count is tied to zero.
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int RETRY_LIMIT   = 3
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_lock_sequencer_if.slave   pll_if
);

  // One shared counter serves every timed state, so it is sized for the
  // largest parameter. Terminal values are at most parameter-1, which fits.
  localparam int MAX_RT  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_RTS = (MAX_RT > STABLE_CYCLES) ? MAX_RT : STABLE_CYCLES;
  localparam int MAX_ALL = (MAX_RTS > RETRY_LIMIT) ? MAX_RTS : RETRY_LIMIT;
  localparam int CNT_W   = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]       RETRY_MAX    = 3'(RETRY_LIMIT);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic             pll_rst_q, pll_rst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic [1:0]       sync_q;
  logic             lock_s;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous PLL locked output.
  // -------------------------------------------------------------------------
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_if.pll_locked};
    end
  end

  assign lock_s = sync_q[1];

  // -------------------------------------------------------------------------
  // State, counter and registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= 3'd0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state, retry bookkeeping and output decode.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;

    if (pll_if.relock_req) begin
      // Restart from scratch regardless of the current state; in RESET_PLL
      // this also restarts the reset interval via the counter clear below.
      state_d = ST_RESET_PLL;
      retry_d = 3'd0;
    end else begin
      unique case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RESET_LAST) begin
            state_d = ST_WAIT_LOCK;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock is tested before the timeout so a lock arriving on the
          // final timeout cycle wins and no retry is charged.
          if (lock_s) begin
            state_d = ST_STABILIZE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              retry_d = retry_q + 3'd1;
              state_d = ST_RESET_PLL;
            end
          end
        end

        ST_STABILIZE: begin
          // Any low sample drops back to WAIT_LOCK, so reaching the last
          // count implies an unbroken run of locked cycles.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = 3'd0;
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RESET_PLL;
          end
        end

        ST_FAULT: begin
          state_d = ST_FAULT;
        end

        default: begin
          state_d = ST_RESET_PLL;
        end
      endcase
    end

    // The counter measures time spent in the current state, so it restarts
    // on every state change and on any relock request.
    if (pll_if.relock_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RESET_PLL) || (state_q == ST_WAIT_LOCK) ||
                 (state_q == ST_STABILIZE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Outputs decode the next state so they change on the same edge as the
    // state register while still coming straight from flops.
    pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  assign pll_if.pll_rst     = pll_rst_q;
  assign pll_if.ready       = ready_q;
  assign pll_if.fault       = fault_q;
  assign pll_if.retry_count = retry_q;

  // -------------------------------------------------------------------------
  // Lock-loss event counter.
  // -------------------------------------------------------------------------
`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] loss_q, loss_d;
  logic       loss_event;

  // A relock request takes precedence over the lock-loss transition, so the
  // exit from RUN is not attributed to lock loss in that case.
  assign loss_event = (state_q == ST_RUN) && !lock_s && !pll_if.relock_req;

  always_comb begin
    loss_d = loss_q;
    if (loss_event && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= 8'd0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign pll_if.loss_count = loss_q;
`else
  assign pll_if.loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Directed scenarios for bring-up, timeout/fault, stabilise glitch, lock loss,
// relock and mid-sequence reset, followed by a randomized run checked cycle
// by cycle against a behavioural model. The model tracks a phase plus the
// number of cycles left in that phase's budget, and treats the synchronizer
// as a two-deep history of pll_locked.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam int R = 4;   // RESET_CYCLES
  localparam int T = 20;  // LOCK_TIMEOUT
  localparam int S = 8;   // STABLE_CYCLES
  localparam int L = 2;   // RETRY_LIMIT

`ifdef PLL_SEQ_LOSS_COUNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;
  localparam int P_FLT  = 4;

  logic refclk = 1'b0;
  logic rst_r = 1'b1;
  logic relock_r = 1'b0;
  logic locked_r = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int m_phase = P_RST;
  int m_left  = R;
  int m_retry = 0;
  int m_loss  = 0;
  bit m_s1 = 1'b0;
  bit m_s2 = 1'b0;

  pll_lock_sequencer_if bus ();

  assign bus.pll_locked = locked_r;
  assign bus.relock_req = relock_r;

  pll_lock_sequencer #(
    .RESET_CYCLES (R),
    .LOCK_TIMEOUT (T),
    .STABLE_CYCLES(S),
    .RETRY_LIMIT  (L)
  ) dut (
    .refclk(refclk),
    .rst   (rst_r),
    .pll_if(bus)
  );

  always #5 refclk = ~refclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Model update for one rising edge with the inputs present at that edge.
  task automatic model_edge(input bit r, input bit rq, input bit lk);
    bit ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = lk;
    if (r) begin
      m_phase = P_RST; m_left = R; m_retry = 0; m_loss = 0;
      m_s1 = 1'b0; m_s2 = 1'b0;
    end else if (rq) begin
      m_phase = P_RST; m_left = R; m_retry = 0;
    end else begin
      case (m_phase)
        P_RST: begin
          m_left--;
          if (m_left == 0) begin m_phase = P_WAIT; m_left = T; end
        end
        P_WAIT: begin
          if (ls) begin
            m_phase = P_STAB; m_left = S;
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (m_retry == L) m_phase = P_FLT;
              else begin m_retry++; m_phase = P_RST; m_left = R; end
            end
          end
        end
        P_STAB: begin
          if (!ls) begin
            m_phase = P_WAIT; m_left = T;
          end else begin
            m_left--;
            if (m_left == 0) begin m_phase = P_RUN; m_retry = 0; end
          end
        end
        P_RUN: begin
          if (!ls) begin
            m_phase = P_RST; m_left = R;
            if (LOSS_EN && m_loss < 255) m_loss++;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    model_edge(rst_r, relock_r, locked_r);
    #1;
  endtask

  task automatic test_reset();
    rst_r = 1'b1; relock_r = 1'b0; locked_r = 1'b0;
    tick(); tick();
    $display("test_reset");
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_bad++; $display("FAIL reset_pll_rst got %b want 1", bus.pll_rst); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", bus.ready); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %b want 0", bus.fault); end
    n_cmp++; if (bus.retry_count !== 3'd0) begin n_bad++; $display("FAIL reset_retry got %0d want 0", bus.retry_count); end
    n_cmp++; if (bus.loss_count !== 8'd0) begin n_bad++; $display("FAIL reset_loss got %0d want 0", bus.loss_count); end
  endtask

  // Release reset, measure the pll_rst pulse, raise lock 10 cycles after
  // release and measure edges until ready. Lock is sampled at edge 1,
  // lock_s is high after edge 2, STABILIZE entered at edge 3, S cycles later
  // RUN: ready appears after edge S+3.
  task automatic test_bringup();
    int n; int t;
    $display("test_bringup");
    rst_r = 1'b0;
    n = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.pll_rst === 1'b1) n++; else break;
    end
    n_cmp++; if (n !== R) begin n_bad++; $display("FAIL bringup_rst_len got %0d want %0d", n, R); end
    repeat (10 - R) tick();
    locked_r = 1'b1;
    t = 0;
    for (int i = 0; i < 100; i++) begin
      tick(); t++;
      if (bus.ready === 1'b1) break;
    end
    n_cmp++; if (t !== S + 3) begin n_bad++; $display("FAIL bringup_ready_latency got %0d want %0d", t, S + 3); end
    n_cmp++; if (bus.retry_count !== 3'd0) begin n_bad++; $display("FAIL bringup_retry got %0d want 0", bus.retry_count); end
    n_cmp++; if (bus.pll_rst !== 1'b0) begin n_bad++; $display("FAIL bringup_pll_rst got %b want 0", bus.pll_rst); end
  endtask

  task automatic test_lock_loss(input int exp_loss);
    int t;
    $display("test_lock_loss");
    locked_r = 1'b0;
    t = 0;
    for (int i = 0; i < 50; i++) begin
      tick(); t++;
      if (bus.ready !== 1'b1) break;
    end
    n_cmp++; if (t !== 3) begin n_bad++; $display("FAIL loss_ready_fall got %0d want 3", t); end
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_bad++; $display("FAIL loss_pll_rst got %b want 1", bus.pll_rst); end
    n_cmp++; if (bus.loss_count !== 8'(exp_loss)) begin n_bad++; $display("FAIL loss_count got %0d want %0d", bus.loss_count, exp_loss); end
  endtask

  // Glitch one cycle into STABILIZE: the drop is sampled at edge 1, seen as
  // lock_s low at edge 3 (back to WAIT_LOCK), lock_s high again at edge 4
  // (STABILIZE), then S fresh cycles: ready after edge S+4.
  task automatic test_glitch();
    int t;
    $display("test_glitch");
    locked_r = 1'b0;
    repeat (6) tick();
    locked_r = 1'b1;
    repeat (7) tick();
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL glitch_early_ready got %b want 0", bus.ready); end
    locked_r = 1'b0;
    tick();
    locked_r = 1'b1;
    t = 1;
    for (int i = 0; i < 100; i++) begin
      if (bus.ready === 1'b1) break;
      tick(); t++;
    end
    n_cmp++; if (t !== S + 4) begin n_bad++; $display("FAIL glitch_ready_latency got %0d want %0d", t, S + 4); end
    n_cmp++; if (bus.retry_count !== 3'd0) begin n_bad++; $display("FAIL glitch_retry got %0d want 0", bus.retry_count); end
  endtask

  task automatic test_no_lock();
    int fault_idx; int pulses; int retry_a; int retry_b; int low_seen;
    logic prev;
    $display("test_no_lock");
    locked_r = 1'b0; rst_r = 1'b1;
    tick();
    rst_r = 1'b0;
    fault_idx = -1; pulses = 1; retry_a = -1; retry_b = -1;
    prev = bus.pll_rst;
    for (int idx = 1; idx <= 200; idx++) begin
      tick();
      if (idx == 30) retry_a = int'(bus.retry_count);
      if (idx == 60) retry_b = int'(bus.retry_count);
      if (bus.fault === 1'b1) begin fault_idx = idx; break; end
      if (bus.pll_rst === 1'b1 && prev === 1'b0) pulses++;
      prev = bus.pll_rst;
    end
    n_cmp++; if (fault_idx !== R + 3 * T + L * R) begin n_bad++; $display("FAIL nolock_fault_time got %0d want %0d", fault_idx, R + 3 * T + L * R); end
    n_cmp++; if (pulses !== L + 1) begin n_bad++; $display("FAIL nolock_pulses got %0d want %0d", pulses, L + 1); end
    n_cmp++; if (retry_a !== 1) begin n_bad++; $display("FAIL nolock_retry_first got %0d want 1", retry_a); end
    n_cmp++; if (retry_b !== 2) begin n_bad++; $display("FAIL nolock_retry_second got %0d want 2", retry_b); end
    n_cmp++; if (bus.retry_count !== 3'(L)) begin n_bad++; $display("FAIL nolock_retry_final got %0d want %0d", bus.retry_count, L); end
    low_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.pll_rst !== 1'b1 || bus.fault !== 1'b1) low_seen++;
    end
    n_cmp++; if (low_seen !== 0) begin n_bad++; $display("FAIL nolock_fault_hold got %0d bad cycles want 0", low_seen); end
  endtask

  task automatic test_relock();
    int n; int t;
    $display("test_relock");
    relock_r = 1'b1;
    tick();
    relock_r = 1'b0;
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL relock_fault got %b want 0", bus.fault); end
    n_cmp++; if (bus.retry_count !== 3'd0) begin n_bad++; $display("FAIL relock_retry got %0d want 0", bus.retry_count); end
    n = (bus.pll_rst === 1'b1) ? 1 : 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.pll_rst === 1'b1) n++; else break;
    end
    n_cmp++; if (n !== R) begin n_bad++; $display("FAIL relock_rst_len got %0d want %0d", n, R); end
    locked_r = 1'b1;
    t = 0;
    for (int i = 0; i < 100; i++) begin
      tick(); t++;
      if (bus.ready === 1'b1) break;
    end
    n_cmp++; if (t !== S + 3) begin n_bad++; $display("FAIL relock_ready_latency got %0d want %0d", t, S + 3); end
  endtask

  task automatic test_rst_mid();
    $display("test_rst_mid");
    // Lose lock once so the loss counter (when built) is non-zero before reset.
    test_lock_loss(LOSS_EN ? 1 : 0);
    locked_r = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (m_phase == P_STAB) break;
    end
    repeat (2) tick();
    rst_r = 1'b1;
    tick();
    rst_r = 1'b0;
    n_cmp++; if (bus.pll_rst !== 1'b1) begin n_bad++; $display("FAIL rstmid_pll_rst got %b want 1", bus.pll_rst); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready got %b want 0", bus.ready); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL rstmid_fault got %b want 0", bus.fault); end
    n_cmp++; if (bus.retry_count !== 3'd0) begin n_bad++; $display("FAIL rstmid_retry got %0d want 0", bus.retry_count); end
    n_cmp++; if (bus.loss_count !== 8'd0) begin n_bad++; $display("FAIL rstmid_loss got %0d want 0", bus.loss_count); end
  endtask

  task automatic test_random();
    int seg; bit lv;
    logic [13:0] got; logic [13:0] exp;
    $display("test_random");
    rst_r = 1'b1; relock_r = 1'b0; locked_r = 1'b0;
    tick();
    rst_r = 1'b0;
    seg = 0; lv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        lv  = ~lv;
        seg = lv ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 90));
      end
      seg--;
      locked_r = lv;
      relock_r = ($urandom_range(0, 149) == 0);
      rst_r    = ($urandom_range(0, 599) == 0);
      tick();
      got = {bus.pll_rst, bus.ready, bus.fault, bus.retry_count, bus.loss_count};
      exp = {(m_phase == P_RST) || (m_phase == P_FLT), m_phase == P_RUN, m_phase == P_FLT,
             3'(m_retry), 8'(m_loss)};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random_cycle_%0d got rst/rdy/flt/retry/loss=%b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                 i, got[13], got[12], got[11], got[10:8], got[7:0],
                 exp[13], exp[12], exp[11], exp[10:8], exp[7:0]);
      end
    end
    relock_r = 1'b0; rst_r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss(LOSS_EN ? 1 : 0);
    test_glitch();
    test_no_lock();
    test_relock();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
